// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared fetch-stage constants and FSM state encoding
package riscv_pkg;

    localparam int          XLEN             = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQ       = 2'd1,
        WAIT      = 2'd2,
        WAIT_DROP = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_if.sv
// rtl/instruction_fetch_if.sv - imem request/response, core issue and redirect channels
interface instruction_fetch_if #(parameter int XLEN = riscv_pkg::XLEN);

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;
    logic            if_valid;
    logic            if_ready;
    logic [31:0]     if_instr;
    logic [XLEN-1:0] if_pc;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;

    modport master (
        output imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready,
               redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready,
               redirect_valid, redirect_pc
    );

endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - small synchronous FIFO holding {instr, pc} pairs with flush
module fetch_fifo #(
    parameter  int DEPTH = 2,
    parameter  int WIDTH = 64,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [CW-1:0]    count_o,
    output logic [WIDTH-1:0] head_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, rptr_q;
    logic [CW-1:0]    count_q;
    logic             empty, full, do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop_i && !empty;
    // A pop frees the slot being written, so push-while-full is legal when popping.
    assign do_push = push_i && (!full || do_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wptr_q] <= push_data_i;
    end

    assign count_o = count_q;
    assign head_o  = empty ? '0 : mem_q[rptr_q];

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - PC owner and single-outstanding fetch FSM feeding the issue FIFO
module instruction_fetch #(
    parameter int              XLEN       = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC   = riscv_pkg::RESET_PC_DEFAULT,
    parameter int              FIFO_DEPTH = 2
) (
    input logic                  clk,
    input logic                  reset,
    instruction_fetch_if.master  bus
);
    import riscv_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int DW = 32 + XLEN;

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic            push, pop, flush;
    logic [CW-1:0]   count, count_after_pop, count_after_push;
    logic [DW-1:0]   head;

    fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DW)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_i     (push),
        .push_data_i({bus.imem_rsp_data, req_pc_q}),
        .pop_i      (pop),
        .flush_i    (flush),
        .count_o    (count),
        .head_o     (head)
    );

    assign pop              = bus.if_valid && bus.if_ready;
    assign count_after_pop  = count - CW'(pop);
    assign count_after_push = count_after_pop + 1'b1;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        push     = 1'b0;
        flush    = 1'b0;
        if (bus.redirect_valid) begin
            // Any request already accepted by memory still owes a response; WAIT_DROP eats it.
            pc_d  = bus.redirect_pc & ~XLEN'(3);
            flush = 1'b1;
            unique case (state_q)
                REQ:             state_d = bus.imem_req_ready ? WAIT_DROP : REQ;
                WAIT, WAIT_DROP: state_d = bus.imem_rsp_valid ? REQ : WAIT_DROP;
                default:         state_d = REQ;
            endcase
        end else begin
            unique case (state_q)
                REQ: begin
                    if (bus.imem_req_ready) begin
                        req_pc_d = pc_q;
                        pc_d     = pc_q + XLEN'(4);
                        state_d  = WAIT;
                    end
                end
                WAIT: begin
                    if (bus.imem_rsp_valid) begin
                        push    = 1'b1;
                        state_d = (count_after_push < CW'(FIFO_DEPTH)) ? REQ : IDLE;
                    end
                end
                WAIT_DROP: begin
                    if (bus.imem_rsp_valid) state_d = REQ;
                end
                default: begin
                    if (count_after_pop < CW'(FIFO_DEPTH)) state_d = REQ;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= REQ;
            pc_q     <= RESET_PC & ~XLEN'(3);
            req_pc_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
        end
    end

    assign bus.imem_req_valid = reset && (state_q == REQ);
    assign bus.imem_req_addr  = pc_q;
    assign bus.if_valid       = (count != '0);
    assign bus.if_instr       = head[DW-1:XLEN];
    assign bus.if_pc          = head[XLEN-1:0];

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - directed bench with memory and core models around instruction_fetch
module tb_instruction_fetch;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    instruction_fetch_if #(.XLEN(32)) bus ();
    instruction_fetch_if #(.XLEN(32)) bus2 ();

    instruction_fetch #(.XLEN(32), .RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    instruction_fetch #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(2)) dut_wrap (
        .clk  (clk),
        .reset(reset),
        .bus  (bus2)
    );

    int          n_pass = 0;
    int          n_total = 0;
    int          lat = 1;
    int          stall = 0;
    int          timer = 0;
    int          req_count = 0;
    bit          pend = 1'b0;
    logic [31:0] paddr = '0;
    logic [31:0] x5 = '0;
    logic [31:0] pc_log[$];
    logic [31:0] instr_log[$];

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0780_0293;
            32'h0000_0004: return 32'h0C80_0293;
            default:       return {a[11:0], 20'h00013} ^ {12'h000, a[31:12]};
        endcase
    endfunction

    function automatic logic [31:0] lg_pc(input int i);
        if (i < pc_log.size()) return pc_log[i];
        return 'x;
    endfunction

    function automatic logic [31:0] lg_instr(input int i);
        if (i < instr_log.size()) return instr_log[i];
        return 'x;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic cyc();
        logic [31:0] ins;
        #1;
        if (reset && bus.imem_req_valid && bus.imem_req_ready) begin
            pend = 1'b1;
            timer = lat;
            paddr = bus.imem_req_addr;
            req_count++;
        end
        if (bus.if_valid && bus.if_ready) begin
            ins = bus.if_instr;
            pc_log.push_back(bus.if_pc);
            instr_log.push_back(ins);
            if (ins[6:0] == 7'h13 && ins[11:7] == 5'd5 && ins[14:12] == 3'd0 && ins[19:15] == 5'd0)
                x5 = {{20{ins[31]}}, ins[31:20]};
        end
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        if (pend) begin
            timer--;
            if (timer == 0) begin
                bus.imem_rsp_valid = 1'b1;
                bus.imem_rsp_data  = mem_rd(paddr);
                pend = 1'b0;
            end
        end
        if (stall > 0) begin
            bus.imem_req_ready = 1'b0;
            stall--;
        end else begin
            bus.imem_req_ready = 1'b1;
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        bus.if_ready = 1'b0;
        bus.redirect_valid = 1'b0;
        cyc();
        cyc();
        pend = 1'b0;
        stall = 0;
        bus.imem_rsp_valid = 1'b0;
        pc_log.delete();
        instr_log.delete();
        req_count = 0;
        x5 = '0;
        reset = 1'b1;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        bus.imem_req_ready = 1'b1;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.if_ready       = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus2.imem_req_ready = 1'b0;
        bus2.imem_rsp_valid = 1'b0;
        bus2.imem_rsp_data  = '0;
        bus2.if_ready       = 1'b1;
        bus2.redirect_valid = 1'b0;
        bus2.redirect_pc    = '0;

        repeat (3) cyc();
        chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("rst_if_valid",  32'(bus.if_valid),       32'd0);
        chk("rst_if_instr",  bus.if_instr,            32'd0);
        chk("rst_if_pc",     bus.if_pc,               32'd0);

        // Reset release, 1-cycle memory, core always ready
        reset = 1'b1;
        bus.if_ready = 1'b1;
        #1;
        chk("t1_first_addr", bus.imem_req_addr,       32'h0);
        chk("t1_req_valid",  32'(bus.imem_req_valid), 32'd1);
        cyc();
        chk("t1_no_bypass",  32'(bus.if_valid),       32'd0);
        cyc();
        chk("t1_if_valid",   32'(bus.if_valid),       32'd1);
        chk("t1_if_pc",      bus.if_pc,               32'h0);
        chk("t1_if_instr",   bus.if_instr,            32'h0780_0293);
        chk("t1_next_addr",  bus.imem_req_addr,       32'h4);
        for (int i = 0; i < 20 && pc_log.size() < 2; i++) cyc();
        chk("t1_log_size",   32'(pc_log.size()),      32'd2);
        chk("t1_pc1",        lg_pc(1),                32'h4);
        chk("t1_instr1",     lg_instr(1),             32'h0C80_0293);
        chk("t1_x5",         x5,                      32'd200);

        // Core stalled: FIFO fills to two entries and fetch parks in IDLE
        lat = 1;
        do_reset();
        repeat (10) cyc();
        chk("t2_req_valid",  32'(bus.imem_req_valid), 32'd0);
        chk("t2_if_valid",   32'(bus.if_valid),       32'd1);
        chk("t2_head_pc",    bus.if_pc,               32'h0);
        chk("t2_req_count",  32'(req_count),          32'd2);
        bus.if_ready = 1'b1;
        for (int i = 0; i < 20 && pc_log.size() < 3; i++) cyc();
        chk("t2_pc0",        lg_pc(0),                32'h0);
        chk("t2_pc1",        lg_pc(1),                32'h4);
        chk("t2_pc2",        lg_pc(2),                32'h8);
        chk("t2_instr2",     lg_instr(2),             32'h0080_0013);

        // Memory back-pressure for three cycles while requesting pc=8
        do_reset();
        bus.if_ready = 1'b1;
        repeat (3) cyc();
        stall = 3;
        cyc();
        chk("t3_addr_s0",    bus.imem_req_addr,       32'h8);
        chk("t3_valid_s0",   32'(bus.imem_req_valid), 32'd1);
        cyc();
        chk("t3_addr_s1",    bus.imem_req_addr,       32'h8);
        cyc();
        chk("t3_addr_s2",    bus.imem_req_addr,       32'h8);
        chk("t3_req_count",  32'(req_count),          32'd2);
        cyc();
        chk("t3_addr_acc",   bus.imem_req_addr,       32'h8);
        cyc();
        cyc();
        chk("t3_if_valid",   32'(bus.if_valid),       32'd1);
        chk("t3_if_pc",      bus.if_pc,               32'h8);
        chk("t3_next_addr",  bus.imem_req_addr,       32'hC);
        chk("t3_req_count2", 32'(req_count),          32'd3);

        // Redirect while waiting on a 3-cycle memory response
        lat = 3;
        do_reset();
        bus.if_ready = 1'b1;
        cyc();
        chk("t4_wait_valid", 32'(bus.imem_req_valid), 32'd0);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0100;
        cyc();
        chk("t4_drop_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("t4_drop_empty", 32'(bus.if_valid),       32'd0);
        cyc();
        cyc();
        chk("t4_new_addr",   bus.imem_req_addr,       32'h100);
        chk("t4_new_valid",  32'(bus.imem_req_valid), 32'd1);
        chk("t4_still_empty",32'(bus.if_valid),       32'd0);
        for (int i = 0; i < 20 && pc_log.size() < 1; i++) cyc();
        chk("t4_first_pc",   lg_pc(0),                32'h100);
        chk("t4_first_instr",lg_instr(0),             32'h1000_0013);

        // Unaligned redirect coinciding with a response and a pop
        lat = 1;
        do_reset();
        cyc();
        cyc();
        cyc();
        chk("t5_head_pc",    bus.if_pc,               32'h0);
        bus.if_ready       = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0203;
        cyc();
        chk("t5_new_addr",   bus.imem_req_addr,       32'h200);
        chk("t5_new_valid",  32'(bus.imem_req_valid), 32'd1);
        chk("t5_flushed",    32'(bus.if_valid),       32'd0);
        chk("t5_popped_pc",  lg_pc(0),                32'h0);
        for (int i = 0; i < 20 && pc_log.size() < 2; i++) cyc();
        chk("t5_resume_pc",  lg_pc(1),                32'h200);
        chk("t5_resume_ins", lg_instr(1),             32'h2000_0013);

        // PC wrap-around from RESET_PC = 0xFFFF_FFFC
        do_reset();
        chk("t6_first_addr", bus2.imem_req_addr,       32'hFFFF_FFFC);
        chk("t6_first_valid",32'(bus2.imem_req_valid), 32'd1);
        bus2.imem_req_ready = 1'b1;
        cyc();
        bus2.imem_req_ready = 1'b0;
        bus2.imem_rsp_valid = 1'b1;
        bus2.imem_rsp_data  = 32'h0000_0013;
        chk("t6_wait_valid", 32'(bus2.imem_req_valid), 32'd0);
        cyc();
        bus2.imem_rsp_valid = 1'b0;
        chk("t6_wrap_addr",  bus2.imem_req_addr,       32'h0);
        chk("t6_wrap_valid", 32'(bus2.imem_req_valid), 32'd1);
        chk("t6_if_pc",      bus2.if_pc,               32'hFFFF_FFFC);
        chk("t6_if_instr",   bus2.if_instr,            32'h0000_0013);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
